// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin N-to-1 arbiter with a one-deep valid/ready output register
// Define MUX_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority instead of round-robin.
module mux_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]  ack,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_sel
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [SW-1:0] ptr, g;
  logic cap;
  assign cap = rst_n && |req && (state == EMPTY || out_ready);
  assign ack = cap ? N'(1) << g : '0;
  assign out_valid = state == FULL;
  // Scan in reverse search order so the last hit is the first index after ptr.
  always_comb begin
    g = '0;
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) g = SW'(i);
`else
    for (int i = N; i >= 1; i--)
      if (req[(int'(ptr) + i) % N]) g = SW'((int'(ptr) + i) % N);
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      out_data <= '0;
      out_sel <= '0;
      ptr <= SW'(N - 1);
    end else if (cap) begin
      state <= FULL;
      out_data <= data[int'(g) * W +: W];
      out_sel <= g;
      ptr <= g;
    end else if (out_ready) state <= EMPTY;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed self-checking bench for mux_rr_arbiter (N=8, W=8).
module tb_mux_rr_arbiter;
  logic clk = 0, rst_n = 0, out_ready = 0, out_valid;
  logic [7:0] req = 0, ack, out_data;
  logic [63:0] data;
  logic [2:0] out_sel;
  logic [7:0] dv [8];
  int n_cmp = 0, n_err = 0;

  mux_rr_arbiter #(.N(8), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < 8; i++) data[i*8 +: 8] = dv[i];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = 8'hFF;
    #1;
    n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL reset_ack got %b want 00000000", ack); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00 || out_sel !== 3'd0) begin n_err++; $display("FAIL reset_regs got %h/%0d want 00/0", out_data, out_sel); end
    step();
    rst_n = 1;
    out_ready = 0;
    req = 8'h01;
    #1;
    n_cmp++; if (ack !== 8'h01) begin n_err++; $display("FAIL first_grant got %b want 00000001", ack); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== dv[0]) begin n_err++; $display("FAIL fill got v=%b %h want v=1 %h", out_valid, out_data, dv[0]); end
    rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0) begin n_err++; $display("FAIL async_reset got v=%b %h/%0d want v=0 00/0", out_valid, out_data, out_sel); end
    n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL reset_ack_full got %b want 00000000", ack); end
    req = 8'h00;
    #1;
    rst_n = 1;
    step();
  endtask

  task automatic test_single();
    dv[2] = 8'hA5;
    out_ready = 1;
    req = 8'b0000_0100;
    #1;
    n_cmp++; if (ack !== 8'b0000_0100) begin n_err++; $display("FAIL single_ack got %b want 00000100", ack); end
    step();
    req = 0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 3'd2) begin n_err++; $display("FAIL single_out got v=%b %h/%0d want v=1 a5/2", out_valid, out_data, out_sel); end
  endtask

  task automatic test_drain();
    #1;
    n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL drain_ack got %b want 00000000", ack); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_sel !== 3'd2 || out_data !== 8'hA5) begin n_err++; $display("FAIL drain got v=%b %h/%0d want v=0 a5/2", out_valid, out_data, out_sel); end
  endtask

  task automatic test_round_robin();
    rst_n = 0;
    #1;
    rst_n = 1;
    out_ready = 1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      #1;
      n_cmp++; if (ack !== 8'(1 << (k % 8))) begin n_err++; $display("FAIL rr_ack[%0d] got %b want %b", k, ack, 8'(1 << (k % 8))); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'(k % 8) || out_data !== dv[k % 8]) begin n_err++; $display("FAIL rr_out[%0d] got v=%b %h/%0d want v=1 %h/%0d", k, out_valid, out_data, out_sel, dv[k % 8], k % 8); end
    end
    req = 0;
    step();
  endtask

  task automatic test_wrap();
    logic [2:0] exp [3];
    exp[0] = 3'd0; exp[1] = 3'd6; exp[2] = 3'd0;
    req = 8'b0100_0000;
    #1;
    n_cmp++; if (ack !== 8'b0100_0000) begin n_err++; $display("FAIL wrap_setup got %b want 01000000", ack); end
    step();
    req = 8'b0100_0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (ack !== 8'(1 << exp[k])) begin n_err++; $display("FAIL wrap_ack[%0d] got %b want %b", k, ack, 8'(1 << exp[k])); end
      step();
      n_cmp++; if (out_sel !== exp[k] || out_data !== dv[exp[k]]) begin n_err++; $display("FAIL wrap_sel[%0d] got %0d/%h want %0d/%h", k, out_sel, out_data, exp[k], dv[exp[k]]); end
    end
    req = 0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    req = 8'h01;
    #1;
    n_cmp++; if (ack !== 8'h01) begin n_err++; $display("FAIL bp_fill got %b want 00000001", ack); end
    step();
    req = 8'hF0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL bp_ack[%0d] got %b want 00000000", k, ack); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== dv[0] || out_sel !== 3'd0) begin n_err++; $display("FAIL bp_hold[%0d] got v=%b %h/%0d want v=1 %h/0", k, out_valid, out_data, out_sel, dv[0]); end
    end
    out_ready = 1;
    #1;
    n_cmp++; if (ack !== 8'h10) begin n_err++; $display("FAIL bp_release_ack got %b want 00010000", ack); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'd4 || out_data !== dv[4]) begin n_err++; $display("FAIL bp_release got v=%b %h/%0d want v=1 %h/4", out_valid, out_data, out_sel, dv[4]); end
    req = 0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_sel !== 3'd4) begin n_err++; $display("FAIL bp_drain got v=%b sel=%0d want v=0 sel=4", out_valid, out_sel); end
  endtask

`ifdef MUX_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    out_ready = 1;
    req = 8'b1000_0011;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (out_sel !== 3'd0) begin n_err++; $display("FAIL fixed_sel[%0d] got %0d want 0", k, out_sel); end
    end
    req = 8'b1000_0010;
    step();
    n_cmp++; if (out_sel !== 3'd1) begin n_err++; $display("FAIL fixed_sel_drop got %0d want 1", out_sel); end
    req = 0;
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) dv[i] = 8'(8'h11 * (i + 1));
    test_reset();
    test_single();
    test_drain();
`ifdef MUX_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
    test_wrap();
`endif
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the N-to-1 data mux. It lets N independent requesters share a single output channel. Each cycle it picks one pending requester and drives the mux select for that requester. It captures the selected word into a one-deep output register and presents it downstream with a valid/ready handshake. It sits between the requester front-ends and the shared consumer.

## Interface
- `N`, default 8: number of requesters; must be ≥2.
- `W`, default 8: data width per requester.
- `SW`, default `$clog2(N)`: select width (derived; do not override).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  N  request vector; bit i high = requester i has a word on its data slice.
- `data`  in  N*W  packed requester data; slice i is `data[i*W +: W]`.
- `ack`  out  N  one-hot grant/accept; high for requester i in the cycle its word is captured.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  downstream accepts the word when high with `out_valid`.
- `out_data`  out  W  captured word.
- `out_sel`  out  SW  index of the requester whose word is in `out_data`.

## Operation
- Two-state FSM: EMPTY (output register free) and FULL (word held).
- Capture condition: `cap = |req && (state==EMPTY || out_ready)`.
  - In FULL with `out_ready` high, drain and capture happen in the same cycle, giving full throughput.
- Grant selection (round-robin):
  - Search indices `ptr+1, ptr+2, …` modulo N.
  - The first index with `req` high wins.
  - `ptr` is the last granted index.
- Actions on `cap`:
  - `ack[g]` is high (combinational) for the winner g.
  - `out_data <= data[g*W +: W]`, `out_sel <= g`, `ptr <= g`, state → FULL.
- Drain without capture: `out_valid && out_ready && !cap` → state EMPTY. `out_data` and `out_sel` keep their last value.
- FULL with `out_ready` low: hold `out_data` and `out_sel` stable, `ack` all zero.
- Requester rules:
  - Hold `req` and data stable until `ack`.
  - May drop `req` before `ack`; the request is then simply not served.
  - A requester with `req` held continuously is served again only after every other active requester has been served once.
- Single requester active: it is granted every capture cycle.
- No requests: `ack` = 0; FULL drains normally.
- `out_valid` = (state==FULL).
- Reset values, applied immediately on `rst_n` low:
  - state EMPTY, so `out_valid` = 0.
  - `out_data` = 0, `out_sel` = 0, `ptr` = N-1 (index 0 wins the first arbitration).
  - `ack` = 0 while in reset.
- A word held at reset assertion is discarded. No ack is replayed.

## Timing
- Latency: `req` high with state EMPTY → `ack` in the same cycle → `out_valid` high the next cycle.
- Throughput: one word per cycle while `out_ready` is high and any `req` is pending.
- `ack` is combinational from `req`, state, `out_ready` and `ptr`. There is no combinational path from `data` to any output.
- `out_valid`, `out_data` and `out_sel` are registered outputs.
- Wrap-around: with `ptr` = N-1, the search starts at 0.

## Configuration
- Macro `MUX_ARB_FIXED_PRIO_EN`.
  - Defined: fixed priority. The lowest-index pending requester always wins and `ptr` is unused. It may be optimized away; starvation of high indices is accepted.
  - Undefined (default): round-robin as above.
- The handshake, FSM and reset behaviour are identical in both builds.

## Test plan
- Reset then single request: assert `rst_n` low mid-FULL, release. `req`=8'b0000_0100 with slice 2 = 8'hA5 → `ack`=8'b0000_0100 that cycle; next cycle `out_valid`=1, `out_data`=8'hA5, `out_sel`=2.
- Round-robin fairness: `req`=8'hFF held, `out_ready`=1 → `out_sel` sequence 0,1,2,…,7,0, one per cycle, each `ack` one-hot.
- Wrap-around: `ptr`=6 (after a grant to 6), `req`=8'b0100_0001 → grant 0; then grant 6; then 0.
- Backpressure: FULL with `out_ready`=0 for 5 cycles and `req`=8'hF0 → `ack`=0 and `out_data` stable. Raise `out_ready` → drain plus capture of index 4 in the same cycle.
- Drain to empty: FULL, `req`=0, `out_ready`=1 → next cycle `out_valid`=0 and `out_sel` unchanged.
- With `MUX_ARB_FIXED_PRIO_EN`: `req`=8'b1000_0011 held, `out_ready`=1 → `out_sel` 0,0,0… until bit 0 drops, then 1.
